// File: rtl/sun_pll_divn_prog.sv
// sun_pll_divn_prog
// Programmable PLL feedback divider with an integrated digital lock detector.
// Everything runs on the rising edge of the oscillator clock CK.
//
// Ports:
//   CK         in   oscillator clock
//   PWRUP_1V8  in   asynchronous active-low reset
//   DIV_N      in   requested divide ratio (quasi-static, 0/1 behave as 2)
//   CK_REF     in   reference clock, asynchronous to CK
//   CK_FB      out  divided clock to the PFD (registered)
//   LOCK       out  lock indication (registered)
//   MEAS       out  last measured reference period in CK cycles (saturating)
module sun_pll_divn_prog #(
  parameter int WIDTH       = 8,
  parameter int TOL         = 1,
  parameter int LOCK_THRESH = 4,
  parameter int MCNT_W      = 4
) (
  input  logic             CK,
  input  logic             PWRUP_1V8,
  input  logic [WIDTH-1:0] DIV_N,
  input  logic             CK_REF,
  output logic             CK_FB,
  output logic             LOCK,
  output logic [WIDTH+1:0] MEAS
);

  localparam int PW = WIDTH + 2;
  localparam logic [WIDTH-1:0]  N_MIN    = WIDTH'(2);
  localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]     ONE_P    = PW'(1);
  localparam logic [PW-1:0]     TOL_P    = PW'(TOL);
  localparam logic [PW-1:0]     PCNT_MAX = {PW{1'b1}};
  localparam logic [MCNT_W-1:0] ONE_M    = MCNT_W'(1);
  localparam logic [MCNT_W-1:0] THRESH_M = MCNT_W'(LOCK_THRESH);

  // divider state
  logic             load_pend_r;
  logic [WIDTH-1:0] n_act_r;
  logic [WIDTH-1:0] div_cnt_r;
  logic             ck_fb_r;

  // reference measurement / lock state
  logic              ref_s1_r;
  logic              ref_s2_r;
  logic              ref_s3_r;
  logic [PW-1:0]     pcnt_r;
  logic [PW-1:0]     meas_r;
  logic [MCNT_W-1:0] mcnt_r;
  logic              lock_r;
  logic              first_edge_r;

  // combinational helpers
  logic [WIDTH-1:0]  n_eff_s;
  logic [WIDTH-1:0]  half_s;
  logic              wrap_s;
  logic              n_chg_s;
  logic              ref_rise_s;
  logic [PW-1:0]     n_act_p_s;
  logic [PW-1:0]     lo_s;
  logic [PW-1:0]     hi_s;
  logic              match_s;
  logic [MCNT_W-1:0] mcnt_inc_s;
  logic [MCNT_W-1:0] mcnt_nxt_s;
  logic              lock_nxt_s;
  logic              first_nxt_s;

  // Effective ratio, wrap detection and ratio-change detection.
  always_comb begin
    n_eff_s = (DIV_N < N_MIN) ? N_MIN : DIV_N;
    half_s  = {1'b0, n_act_r[WIDTH-1:1]};
    wrap_s  = (div_cnt_r == (n_act_r - ONE_W));
    // A ratio change only takes effect at a wrap, so that is where lock is lost.
    n_chg_s = wrap_s && !load_pend_r && (n_eff_s != n_act_r);
  end

  // Divider counter, shadow ratio and registered feedback clock.
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      load_pend_r <= 1'b1;
      n_act_r     <= N_MIN;
      div_cnt_r   <= {WIDTH{1'b0}};
      ck_fb_r     <= 1'b0;
    end else if (load_pend_r) begin
      // First clock after release only captures the ratio; counting starts next.
      load_pend_r <= 1'b0;
      n_act_r     <= n_eff_s;
      div_cnt_r   <= {WIDTH{1'b0}};
      ck_fb_r     <= 1'b0;
    end else begin
      load_pend_r <= 1'b0;
      ck_fb_r     <= (div_cnt_r < half_s);
      if (wrap_s) begin
        div_cnt_r <= {WIDTH{1'b0}};
        n_act_r   <= n_eff_s;
      end else begin
        div_cnt_r <= div_cnt_r + ONE_W;
        n_act_r   <= n_act_r;
      end
    end
  end

  // Reference edge detect after the two-flop synchronizer.
  always_comb begin
    ref_rise_s = ref_s2_r & ~ref_s3_r;
  end

  // Tolerance window around the active ratio; lower bound clamps at zero.
  always_comb begin
    n_act_p_s = {2'b00, n_act_r};
    hi_s      = n_act_p_s + TOL_P;
    if (n_act_p_s > TOL_P) begin
      lo_s = n_act_p_s - TOL_P;
    end else begin
      lo_s = {PW{1'b0}};
    end
    match_s = (pcnt_r >= lo_s) && (pcnt_r <= hi_s);
  end

  // Match counter / lock next-state; a ratio change overrides any reference result.
  always_comb begin
    mcnt_inc_s  = (mcnt_r >= THRESH_M) ? THRESH_M : (mcnt_r + ONE_M);
    mcnt_nxt_s  = mcnt_r;
    lock_nxt_s  = lock_r;
    first_nxt_s = first_edge_r;
    if (n_chg_s) begin
      mcnt_nxt_s  = {MCNT_W{1'b0}};
      lock_nxt_s  = 1'b0;
      first_nxt_s = ref_rise_s ? 1'b0 : first_edge_r;
    end else if (ref_rise_s) begin
      if (first_edge_r) begin
        // The first period after reset is partial, so it is never compared.
        first_nxt_s = 1'b0;
      end else if (match_s) begin
        mcnt_nxt_s = mcnt_inc_s;
        lock_nxt_s = (mcnt_inc_s == THRESH_M) ? 1'b1 : lock_r;
      end else begin
        mcnt_nxt_s = {MCNT_W{1'b0}};
        lock_nxt_s = 1'b0;
      end
    end else begin
      mcnt_nxt_s  = mcnt_r;
      lock_nxt_s  = lock_r;
      first_nxt_s = first_edge_r;
    end
  end

  // Synchronizer, period counter, measurement and lock registers.
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      ref_s1_r     <= 1'b0;
      ref_s2_r     <= 1'b0;
      ref_s3_r     <= 1'b0;
      pcnt_r       <= {PW{1'b0}};
      meas_r       <= {PW{1'b0}};
      mcnt_r       <= {MCNT_W{1'b0}};
      lock_r       <= 1'b0;
      first_edge_r <= 1'b1;
    end else begin
      ref_s1_r     <= CK_REF;
      ref_s2_r     <= ref_s1_r;
      ref_s3_r     <= ref_s2_r;
      mcnt_r       <= mcnt_nxt_s;
      lock_r       <= lock_nxt_s;
      first_edge_r <= first_nxt_s;
      if (ref_rise_s) begin
        // Count restarts at 1 so the value seen at the next edge is the period.
        pcnt_r <= ONE_P;
        meas_r <= pcnt_r;
      end else begin
        pcnt_r <= (pcnt_r == PCNT_MAX) ? pcnt_r : (pcnt_r + ONE_P);
        meas_r <= meas_r;
      end
    end
  end

  assign CK_FB = ck_fb_r;
  assign LOCK  = lock_r;
  assign MEAS  = meas_r;

endmodule
